reg_bus_arbiter: RTL and testbench

- Shares the single control-register write bus (aBus/dBus/wrEnable) between N_REQ requesters, e.g. the host serial interface and the keyboard scanner.
- Each requester presents an address/data pair with a level request. The arbiter picks one round-robin, drives a fixed 3-cycle write transaction, and returns a one-cycle ack.
- Sits between the requesters and all control registers on the bus.

---
 rtl/reg_bus_arbiter_pkg.sv | 17 +
 rtl/reg_bus_arbiter_rr_pick.sv | 41 ++++
 rtl/reg_bus_arbiter.sv | 118 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_pkg
// Shared types and constants for the control-register write bus arbiter.
//   state_t    : arbiter transaction phase, 2-bit encoding
//   WR_CYCLES  : clock cycles occupied by one complete write transaction
// ---------------------------------------------------------------------------
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  localparam int WR_CYCLES = 3;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches lastGrant+1, lastGrant+2, ...
// modulo N_REQ and reports the first index whose request bit is set.
// Ports:
//   req        in   N_REQ   request vector
//   last_grant in   IDX_W   index granted most recently
//   valid      out  1       at least one request is pending
//   index      out  IDX_W   winning requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  int               w_j;
  logic [IDX_W-1:0] w_idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant is the one left standing.
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_j   = 0;
    w_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_j   = (int'(last_grant) + k) % N_REQ;
      w_idx = IDX_W'(w_j);
      if (req[w_idx]) begin
        valid = 1'b1;
        index = w_idx;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
// Shares the control-register write bus between N_REQ requesters. A winner is
// picked round-robin in IDLE, its address/data are latched onto the bus, the
// bus is held stable for one SETUP cycle, then wrEnable and a one-hot ack are
// pulsed together in STROBE. All outputs are registered.
// Ports:
//   clk       in   1               system clock, rising edge
//   rst       in   1               asynchronous active-high reset
//   req       in   N_REQ           per-requester level request
//   reqAddr   in   N_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   reqData   in   N_REQ*DATA_W    packed data, requester i at [i*DATA_W +: DATA_W]
//   ack       out  N_REQ           one-cycle one-hot pulse with the write strobe
//   aBus      out  ADDR_W          register bus address
//   dBus      out  DATA_W          register bus data
//   wrEnable  out  1               register bus write strobe
//   busy      out  1               high during SETUP and STROBE
//   grantId   out  clog2(N_REQ)    current or last granted requester
// ---------------------------------------------------------------------------
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int N_REQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_W-1:0]    reqAddr,
  input  logic [N_REQ*DATA_W-1:0]    reqData,
  output logic [N_REQ-1:0]           ack,
  output logic [ADDR_W-1:0]          aBus,
  output logic [DATA_W-1:0]          dBus,
  output logic                       wrEnable,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grantId
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           r_state;
  logic [IDX_W-1:0] r_last_grant;

  logic             w_valid;
  logic [IDX_W-1:0] w_index;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [N_REQ-1:0] w_ack_onehot;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req        (req),
    .last_grant (r_last_grant),
    .valid      (w_valid),
    .index      (w_index)
  );

  // Constant-base slices keep the mux free of variable part-selects.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_index == IDX_W'(i)) begin
        w_sel_addr = reqAddr[i*ADDR_W +: ADDR_W];
        w_sel_data = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ack_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grantId;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(N_REQ-1);
      aBus         <= '0;
      dBus         <= '0;
      wrEnable     <= 1'b0;
      ack          <= '0;
      busy         <= 1'b0;
      grantId      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            aBus    <= w_sel_addr;
            dBus    <= w_sel_data;
            grantId <= w_index;
            busy    <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          // Bus has been stable for a full cycle; strobe next.
          wrEnable <= 1'b1;
          ack      <= w_ack_onehot;
          r_state  <= STROBE;
        end
        STROBE: begin
          wrEnable     <= 1'b0;
          ack          <= '0;
          busy         <= 1'b0;
          r_last_grant <= grantId;
          r_state      <= IDLE;
        end
        default: begin
          wrEnable <= 1'b0;
          ack      <= '0;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;
  import reg_bus_pkg::WR_CYCLES;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] reqAddr = '0;
  logic [N*DW-1:0] reqData = '0;
  logic [N-1:0]    ack;
  logic [AW-1:0]   aBus;
  logic [DW-1:0]   dBus;
  logic            wrEnable;
  logic            busy;
  logic [$clog2(N)-1:0] grantId;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a write is a 3-cycle slot counted by m_phase
  // (0 = waiting, 1 = bus settling, 2 = strobing).
  int           m_phase;
  int           m_last;
  int           m_id;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int cyc = 0;
  int waited [N];

  always #5 clk = ~clk;

  reg_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .reqAddr(reqAddr), .reqData(reqData),
    .ack(ack), .aBus(aBus), .dBus(dBus), .wrEnable(wrEnable), .busy(busy),
    .grantId(grantId)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = N-1;
    m_id    = 0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit found;
    int j;
    found = 0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (!found && req[j]) begin
            found  = 1;
            m_id   = j;
            m_addr = reqAddr[j*AW +: AW];
            m_data = reqData[j*DW +: DW];
            m_phase = 1;
          end
        end
      end
      1: m_phase = 2;
      default: begin
        m_last  = m_id;
        m_phase = 0;
      end
    endcase
  endtask

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] a;
    a = '0;
    if (m_phase == 2) a[m_id] = 1'b1;
    return a;
  endfunction

  task automatic check_outputs();
    chk("wrEnable", 32'(wrEnable), 32'(m_phase == 2));
    chk("busy",     32'(busy),     32'(m_phase != 0));
    chk("ack",      32'(ack),      32'(exp_ack()));
    chk("aBus",     32'(aBus),     32'(m_addr));
    chk("dBus",     32'(dBus),     32'(m_data));
    chk("grantId",  32'(grantId),  32'(m_id));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic set_req(input int i, input bit on, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = on;
    reqAddr[i*AW +: AW] = a;
    reqData[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    int grants [$];
    int wr_cyc [$];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    int r;

    // Reset state
    do_reset();

    // Single request
    set_req(0, 1, 4'h3, 8'hA5);
    tick();
    chk("single_busy_setup", 32'(busy), 32'd1);
    chk("single_wr_setup", 32'(wrEnable), 32'd0);
    tick();
    chk("single_wr", 32'(wrEnable), 32'd1);
    chk("single_aBus", 32'(aBus), 32'h3);
    chk("single_dBus", 32'(dBus), 32'hA5);
    chk("single_ack", 32'(ack), 32'b01);
    set_req(0, 0, 4'h3, 8'hA5);
    tick();
    chk("single_busy_end", 32'(busy), 32'd0);
    tick();

    // Simultaneous first request after reset
    do_reset();
    set_req(0, 1, 4'h1, 8'h10);
    set_req(1, 1, 4'h2, 8'h20);
    tick(); tick();
    chk("simul_ack0", 32'(ack), 32'b01);
    set_req(0, 0, 4'h1, 8'h10);
    tick(); tick(); tick();
    chk("simul_ack1", 32'(ack), 32'b10);
    chk("simul_aBus1", 32'(aBus), 32'h2);
    set_req(1, 0, 4'h2, 8'h20);
    tick();

    // Fairness: both held for 12 cycles
    set_req(0, 1, 4'h7, 8'h70);
    set_req(1, 1, 4'h8, 8'h80);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (wrEnable) begin
        grants.push_back(int'(grantId));
        wr_cyc.push_back(cyc);
      end
    end
    req = '0;
    tick(); tick();
    chk("fair_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("fair_order", 32'(grants[i]), 32'(i % 2));
    for (int i = 1; i < wr_cyc.size(); i++)
      chk("fair_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(WR_CYCLES));

    // Back-to-back from requester 1 with new addr/data on its ack
    wr_cyc.delete();
    set_req(1, 1, 4'h5, 8'h11);
    for (int c = 0; c < 12 && wr_cyc.size() < 2; c++) begin
      tick();
      if (wrEnable) begin
        wr_cyc.push_back(cyc);
        wr_a.push_back(aBus);
        wr_d.push_back(dBus);
        if (wr_cyc.size() == 1) set_req(1, 1, 4'h6, 8'h22);
        else                    set_req(1, 0, 4'h6, 8'h22);
      end
    end
    chk("b2b_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) begin
      chk("b2b_a0", 32'(wr_a[0]), 32'h5);
      chk("b2b_d0", 32'(wr_d[0]), 32'h11);
      chk("b2b_a1", 32'(wr_a[1]), 32'h6);
      chk("b2b_d1", 32'(wr_d[1]), 32'h22);
      chk("b2b_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'(WR_CYCLES));
    end
    req = '0;
    tick();

    // Withdrawal in SETUP
    set_req(0, 1, 4'h9, 8'h3C);
    tick();
    set_req(0, 0, 4'hF, 8'hFF);
    tick();
    chk("withdraw_wr", 32'(wrEnable), 32'd1);
    chk("withdraw_ack", 32'(ack), 32'b01);
    chk("withdraw_aBus", 32'(aBus), 32'h9);
    chk("withdraw_dBus", 32'(dBus), 32'h3C);
    tick();

    // Reset during STROBE
    set_req(0, 1, 4'hA, 8'h5A);
    set_req(1, 1, 4'hB, 8'h6B);
    tick(); tick();
    chk("rst_pre_wr", 32'(wrEnable), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_async", 32'(wrEnable), 32'd0);
    chk("rst_ack_async", 32'(ack), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst = 1'b0;
    tick(); tick();
    chk("rst_tie_ack", 32'(ack), 32'b01);
    req = '0;
    tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < N; i++) waited[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_phase == 2 && m_id == i) begin
          chk("starve_bound", 32'(waited[i] <= 3*N + WR_CYCLES), 32'd1);
          waited[i] = 0;
          r = $urandom_range(2);
          if (r == 0)      set_req(i, 0, 4'($urandom), 8'($urandom));
          else if (r == 1) set_req(i, 1, 4'($urandom), 8'($urandom));
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) set_req(i, 1, 4'($urandom), 8'($urandom));
        end else if (m_phase == 1 && m_id == i) begin
          r = $urandom_range(7);
          if (r == 0) begin
            set_req(i, 0, 4'($urandom), 8'($urandom));
            waited[i] = 0;
          end else if (r == 1) begin
            set_req(i, 1, 4'($urandom), 8'($urandom));
          end
        end
      end
      tick();
      for (int i = 0; i < N; i++)
        if (req[i]) waited[i]++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
